// File: rtl/cp0_exc_handler.sv
// cp0_exc_handler: coprocessor-0 exception/interrupt decision and SR/Cause/EPC/PRId storage.
// Sits beside the M stage; IntReq flushes the pipeline and redirects fetch to the handler.
module cp0_exc_handler #(
  parameter logic [31:0] PRID    = 32'h2019_0700,
  parameter logic [4:0]  EXC_INT = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        EXLClr,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic        ExcValid,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IM_W   = 6;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned EPC_W  = DATA_W - 2;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [IM_W-1:0]   im_q,   im_d;
  logic              exl_q,  exl_d;
  logic              ie_q,   ie_d;
  // Cause fields
  logic              bd_q,   bd_d;
  logic [IM_W-1:0]   ip_q,   ip_d;
  logic [CODE_W-1:0] code_q, code_d;
  // EPC is word aligned; only bits 31:2 are stored
  logic [EPC_W-1:0]  epc_q,  epc_d;

  logic              irq_c;
  logic              exc_c;
  logic [DATA_W-1:0] epc_src_c;
  logic [DATA_W-1:0] sr_rd_c;
  logic [DATA_W-1:0] cause_rd_c;
  logic [DATA_W-1:0] epc_rd_c;
  logic              unused_pc_low_c;

  // Take decision: enabled pending interrupt or a fresh exception, both masked while in a handler
  always_comb begin
    irq_c  = (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_c  = ExcValid & ~exl_q;
    IntReq = irq_c | exc_c;
  end

  // Return address: a delay-slot instruction restarts at its branch
  always_comb begin
    epc_src_c = BD ? (PC - DATA_W'(4)) : PC;
  end

  // Low PC bits are discarded when captured into EPC
  assign unused_pc_low_c = ^epc_src_c[1:0];

  // Architected read views of the stored registers
  always_comb begin
    sr_rd_c    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    cause_rd_c = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b00};
    epc_rd_c   = {epc_q, 2'b00};
  end

  // mfc0 read mux over stored state (same-cycle mtc0 not bypassed)
  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:    DOut = sr_rd_c;
      REG_CAUSE: DOut = cause_rd_c;
      REG_EPC:   DOut = epc_rd_c;
      REG_PRID:  DOut = PRID;
      default:   DOut = '0;
    endcase
  end

  // eret target comes straight from the EPC register
  assign EPCOut = epc_rd_c;

  // Next-state: exception entry wins over mtc0/eret; eret overrides an mtc0 write of EXL
  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    ip_d   = HWInt;

    if (IntReq) begin
      exl_d  = 1'b1;
      code_d = irq_c ? EXC_INT : ExcCodeIn;
      bd_d   = BD;
      epc_d  = epc_src_c[DATA_W-1:2];
    end else begin
      if (WE) begin
        case (A2)
          REG_SR: begin
            im_d  = DIn[15:10];
            exl_d = DIn[1];
            ie_d  = DIn[0];
          end
          REG_EPC: epc_d = DIn[DATA_W-1:2];
          default: ;
        endcase
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // State registers with immediate asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Bench for cp0_exc_handler: expectations queued at drive time, popped as outputs are sampled.
module tb_cp0_exc_handler;

  localparam logic [31:0] PRID = 32'h2019_0700;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic        EXLClr;
  logic [31:0] PC;
  logic        BD;
  logic        ExcValid;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  cp0_exc_handler #(.PRID(PRID), .EXC_INT(5'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .EXLClr    (EXLClr),
    .PC        (PC),
    .BD        (BD),
    .ExcValid  (ExcValid),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .IntReq    (IntReq),
    .EPCOut    (EPCOut),
    .DOut      (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", obs, ~obs);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  // mfc0 read of register a (one ns settle)
  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] v);
    A1 = a;
    push_exp(tag, v);
    #1;
    pop_cmp(DOut);
  endtask

  task automatic chk_irq(input string tag, input logic v);
    push_exp(tag, 32'(v));
    #1;
    pop_cmp(32'(IntReq));
  endtask

  task automatic chk_epc(input string tag, input logic [31:0] v);
    push_exp(tag, v);
    pop_cmp(EPCOut);
  endtask

  task automatic idle_inputs();
    WE = 1'b0; EXLClr = 1'b0; ExcValid = 1'b0; A2 = 5'd0; DIn = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    A1 = 5'd0; A2 = 5'd0; DIn = '0; WE = 1'b0; EXLClr = 1'b0;
    PC = '0; BD = 1'b0; ExcValid = 1'b0; ExcCodeIn = '0; HWInt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // 1: reset values
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    rd(5'd15, "rst_prid", PRID);
    chk_irq("rst_intreq", 1'b0);

    // 2: enable IM[0]+IE, then interrupt at PC 3010
    @(negedge clk);
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    @(negedge clk);
    idle_inputs();
    rd(5'd12, "sr_written", 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
    chk_irq("irq_same_cycle", 1'b1);
    @(negedge clk);
    rd(5'd14, "irq_epc", 32'h0000_3010);
    rd(5'd13, "irq_cause", 32'h0000_0400);
    rd(5'd12, "irq_sr_exl", 32'h0000_0403);
    chk_irq("irq_masked_by_exl", 1'b0);

    // 3: eret, then exception code 10 in a delay slot
    HWInt = 6'b000000; EXLClr = 1'b1;
    @(negedge clk);
    idle_inputs();
    rd(5'd12, "eret_sr", 32'h0000_0401);
    ExcValid = 1'b1; ExcCodeIn = 5'd10; BD = 1'b1; PC = 32'h0000_3020;
    chk_irq("exc_same_cycle", 1'b1);
    @(negedge clk);
    idle_inputs();
    rd(5'd14, "exc_bd_epc", 32'h0000_301C);
    rd(5'd13, "exc_bd_cause", 32'h8000_0028);
    chk_epc("exc_epcout", 32'h0000_301C);

    // 4: exception ignored while EXL, then eret clears EXL
    ExcValid = 1'b1; ExcCodeIn = 5'd4; BD = 1'b0; PC = 32'h0000_5000;
    chk_irq("exc_ignored_exl", 1'b0);
    @(negedge clk);
    idle_inputs();
    rd(5'd13, "ign_cause", 32'h8000_0028);
    rd(5'd14, "ign_epc", 32'h0000_301C);
    EXLClr = 1'b1;
    @(negedge clk);
    idle_inputs();
    rd(5'd12, "eret2_sr", 32'h0000_0401);

    // 5a: mtc0 EPC collides with interrupt; write discarded
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_4003;
    HWInt = 6'b000001; PC = 32'h0000_6000; BD = 1'b0;
    chk_irq("collide_irq", 1'b1);
    @(negedge clk);
    HWInt = 6'b000000;
    rd(5'd14, "collide_epc", 32'h0000_6000);
    rd(5'd13, "collide_cause", 32'h0000_0400);
    // 5b: plain mtc0 EPC, old value visible in write cycle
    rd(5'd14, "mtc0_epc_old", 32'h0000_6000);
    @(negedge clk);
    idle_inputs();
    rd(5'd14, "mtc0_epc_new", 32'h0000_4000);
    chk_epc("mtc0_epcout", 32'h0000_4000);

    // mtc0 SR with eret in same cycle: EXL cleared, IM/IE written
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1'b1;
    @(negedge clk);
    idle_inputs();
    rd(5'd12, "mtc0_eret_sr", 32'h0000_FC01);
    // mtc0 to Cause and PRId has no effect
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    @(negedge clk);
    A2 = 5'd15;
    @(negedge clk);
    idle_inputs();
    rd(5'd13, "cause_ro", 32'h0000_0000);
    rd(5'd15, "prid_ro", PRID);
    rd(5'd7,  "other_reg", 32'h0);

    // 6: interrupt on HWInt[5] in delay slot, then async reset mid-handler
    HWInt = 6'b100000; PC = 32'h0000_7004; BD = 1'b1;
    chk_irq("irq5", 1'b1);
    @(negedge clk);
    BD = 1'b0;
    rd(5'd13, "irq5_cause", 32'h8000_8000);
    rd(5'd14, "irq5_epc", 32'h0000_7000);
    rd(5'd12, "irq5_sr", 32'h0000_FC03);
    @(negedge clk);
    reset = 1'b1;
    rd(5'd12, "arst_sr", 32'h0);
    rd(5'd13, "arst_cause", 32'h0);
    rd(5'd14, "arst_epc", 32'h0);
    chk_epc("arst_epcout", 32'h0);
    push_exp("arst_intreq", 32'h0);
    pop_cmp(32'(IntReq));
    @(negedge clk);
    reset = 1'b0;
    HWInt = '0;

    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Run-away guard
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
